// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin burst arbiter: requester
// count, grant index width, FSM encoding, watchdog default and the rotation pick.
package arb_pkg;

   localparam int NREQ         = 4;
   localparam int SELW         = 2;
   localparam int WDOG_CYC_DEF = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // First requester with valid set, searching from ptr+1 upward and wrapping.
   function automatic logic [SELW-1:0] rrPick(input logic [SELW-1:0] ptr,
                                              input logic [NREQ-1:0] valid);
      logic [SELW-1:0] idx;
      logic            found;
      rrPick = ptr;
      found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = ptr + SELW'(k);
         if (!found && valid[idx]) begin
            rrPick = idx;
            found  = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_arb4_mux41.sv
// Generic 4:1 multiplexer; the arbiter uses one copy for the payload and one
// for the last flag.
module mux41 #(
   parameter int W = 1
) (
   input  logic [4*W-1:0] d_i,
   input  logic [1:0]     sel_i,
   output logic [W-1:0]   y_o
);

   assign y_o = d_i[sel_i*W +: W];

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin burst arbiter: a grant is held until the granted
// requester's last beat transfers. Macro RR_ARB4_WDOG_EN adds an idle watchdog.
module rr_arb4
   import arb_pkg::*;
#(
   parameter int DW       = 2,
   parameter int WDOG_CYC = WDOG_CYC_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   input  logic [NREQ-1:0]      req_last,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic                 out_last,
   output logic [SELW-1:0]      sel,
   output logic                 busy,
   output logic                 timeout
);

   state_e          state_q;
   logic [SELW-1:0] sel_q;
   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] pickIdx;
   logic [DW-1:0]   muxData;
   logic            muxLast;
   logic            muxValid;
   logic            xferLast;
   logic            wdogFire;

   mux41 #(.W(DW)) uDataMux (
      .d_i   (req_data),
      .sel_i (sel_q),
      .y_o   (muxData)
   );

   mux41 #(.W(1)) uLastMux (
      .d_i   (req_last),
      .sel_i (sel_q),
      .y_o   (muxLast)
   );

   assign muxValid  = req_valid[sel_q];
   assign busy      = (state_q == GRANT);
   assign sel       = sel_q;
   assign out_valid = busy & muxValid;
   assign out_data  = busy ? muxData : '0;
   assign out_last  = busy & muxLast;
   assign xferLast  = out_valid & out_ready & out_last;
   assign pickIdx   = rrPick(ptr_q, req_valid);

   always_comb begin
      req_ready = '0;
      if (busy) begin
         req_ready[sel_q] = out_ready;
      end
   end

`ifdef RR_ARB4_WDOG_EN
   localparam logic [3:0] WDOG_LIM = 4'(WDOG_CYC - 1);

   logic [3:0] wdogCnt_q;

   assign wdogFire = busy & ~muxValid & (wdogCnt_q == WDOG_LIM);
   assign timeout  = wdogFire;

   // Counts consecutive granted cycles in which the owner presents no beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wdogCnt_q <= '0;
      end else if (!busy || muxValid || wdogFire) begin
         wdogCnt_q <= '0;
      end else begin
         wdogCnt_q <= wdogCnt_q + 4'd1;
      end
   end
`else
   // WDOG_CYC stays referenced so both builds share one parameter list.
   assign wdogFire = 1'b0 & (WDOG_CYC != 0);
   assign timeout  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         ptr_q   <= SELW'(3);
      end else begin
         unique case (state_q)
            IDLE: begin
               if (|req_valid) begin
                  sel_q   <= pickIdx;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (xferLast || wdogFire) begin
                  ptr_q   <= sel_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios plus random traffic
// against a cycle-level behavioural model. Honours RR_ARB4_WDOG_EN.
module tb_rr_arb4;
   import arb_pkg::*;

   localparam int DW   = 4;
   localparam int WDOG = 16;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [3:0]        req_valid;
   logic [4*DW-1:0]   req_data;
   logic [3:0]        req_last;
   logic [3:0]        req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic              out_last;
   logic [1:0]        sel;
   logic              busy;
   logic              timeout;

   int total = 0;
   int bad   = 0;
   int xfers = 0;
   logic obsTimeout;

   bit mGrant;
   int mPtr;
   int mSel;
   int mIdle;

   rr_arb4 #(.DW(DW), .WDOG_CYC(WDOG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .sel       (sel),
      .busy      (busy),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, checks outputs against the model, then advances the model.
   task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l,
                                input logic [4*DW-1:0] d, input logic r);
      logic [31:0] expRdy;
      logic [31:0] expTo;
      bit          found;
      @(negedge clk);
      req_valid = v;
      req_last  = l;
      req_data  = d;
      out_ready = r;
      #1;
      expRdy = (mGrant && r) ? (32'd1 << mSel) : 32'd0;
`ifdef RR_ARB4_WDOG_EN
      expTo = (mGrant && !v[mSel] && mIdle == WDOG - 1) ? 32'd1 : 32'd0;
`else
      expTo = 32'd0;
`endif
      checkOutput("out_valid", 32'(out_valid), (mGrant && v[mSel]) ? 32'd1 : 32'd0);
      checkOutput("out_data",  32'(out_data),  mGrant ? 32'(d[mSel*DW +: DW]) : 32'd0);
      checkOutput("out_last",  32'(out_last),  (mGrant && l[mSel]) ? 32'd1 : 32'd0);
      checkOutput("req_ready", 32'(req_ready), expRdy);
      checkOutput("sel",       32'(sel),       32'(mSel));
      checkOutput("busy",      32'(busy),      mGrant ? 32'd1 : 32'd0);
      checkOutput("timeout",   32'(timeout),   expTo);
      obsTimeout = timeout;
      if (out_valid && out_ready) xfers++;
      @(posedge clk);
      if (!mGrant) begin
         if (v != 4'd0) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
               if (!found && v[(mPtr + k) % 4]) begin
                  mSel  = (mPtr + k) % 4;
                  found = 1'b1;
               end
            end
            mGrant = 1'b1;
            mIdle  = 0;
         end
      end else begin
         if (v[mSel] && r && l[mSel]) begin
            mPtr   = mSel;
            mGrant = 1'b0;
         end
`ifdef RR_ARB4_WDOG_EN
         if (v[mSel]) mIdle = 0;
         else if (mIdle == WDOG - 1) begin
            mPtr   = mSel;
            mGrant = 1'b0;
            mIdle  = 0;
         end else mIdle++;
`endif
      end
      #1;
   endtask

   // Asserts reset with the current inputs still applied, checks all outputs
   // clear at once, then releases on a falling edge with idle inputs.
   task automatic doReset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput({tag, "_ov"},   32'(out_valid), 32'd0);
      checkOutput({tag, "_rdy"},  32'(req_ready), 32'd0);
      checkOutput({tag, "_data"}, 32'(out_data),  32'd0);
      checkOutput({tag, "_last"}, 32'(out_last),  32'd0);
      checkOutput({tag, "_busy"}, 32'(busy),      32'd0);
      checkOutput({tag, "_sel"},  32'(sel),       32'd0);
      checkOutput({tag, "_to"},   32'(timeout),   32'd0);
      mGrant = 1'b0;
      mPtr   = 3;
      mSel   = 0;
      mIdle  = 0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic logic [4*DW-1:0] rndData();
      return (4*DW)'($urandom);
   endfunction

   initial begin
      int toCycle;
      int toCount;
      int startX;
      logic [4*DW-1:0] dHold;
      rst_n     = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      out_ready = 1'b0;
      obsTimeout = 1'b0;

      // Single requester, three-beat burst.
      doReset("rst0");
      startX = xfers;
      applyStimulus(4'b0100, 4'b0000, rndData(), 1'b1);
      checkOutput("single_sel", 32'(sel), 32'd2);
      checkOutput("single_busy", 32'(busy), 32'd1);
      applyStimulus(4'b0100, 4'b0000, rndData(), 1'b1);
      applyStimulus(4'b0100, 4'b0000, rndData(), 1'b1);
      applyStimulus(4'b0100, 4'b0100, rndData(), 1'b1);
      checkOutput("single_beats", 32'(xfers - startX), 32'd3);
      checkOutput("single_idle", 32'(busy), 32'd0);
      applyStimulus(4'b1111, 4'b0000, rndData(), 1'b1);
      checkOutput("single_ptr", 32'(sel), 32'd3);
      applyStimulus(4'b1111, 4'b1111, rndData(), 1'b1);

      // Full contention with one-beat bursts.
      doReset("rst1");
      for (int g = 0; g < 5; g++) begin
         applyStimulus(4'b1111, 4'b1111, rndData(), 1'b1);
         checkOutput("rot_sel", 32'(sel), 32'(g % 4));
         checkOutput("rot_busy", 32'(busy), 32'd1);
         applyStimulus(4'b1111, 4'b1111, rndData(), 1'b1);
         checkOutput("rot_idle", 32'(busy), 32'd0);
      end

      // Backpressure in the middle of a burst.
      doReset("rst2");
      startX = xfers;
      applyStimulus(4'b0100, 4'b0000, rndData(), 1'b1);
      applyStimulus(4'b0100, 4'b0000, rndData(), 1'b1);
      dHold = rndData();
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b0100, 4'b0000, dHold, 1'b0);
         checkOutput("bp_rdy", 32'(req_ready), 32'd0);
         checkOutput("bp_data", 32'(out_data), 32'(dHold[2*DW +: DW]));
         checkOutput("bp_sel", 32'(sel), 32'd2);
      end
      checkOutput("bp_nolost", 32'(xfers - startX), 32'd1);
      applyStimulus(4'b0100, 4'b0100, dHold, 1'b1);
      checkOutput("bp_beats", 32'(xfers - startX), 32'd2);
      checkOutput("bp_idle", 32'(busy), 32'd0);

      // A new request during another requester's burst waits for its last beat.
      doReset("rst3");
      applyStimulus(4'b0010, 4'b0000, rndData(), 1'b1);
      checkOutput("mid_sel1", 32'(sel), 32'd1);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b0011, 4'b0000, rndData(), 1'b1);
         checkOutput("mid_hold", 32'(sel), 32'd1);
      end
      applyStimulus(4'b0011, 4'b0010, rndData(), 1'b1);
      checkOutput("mid_idle", 32'(busy), 32'd0);
      applyStimulus(4'b0011, 4'b0000, rndData(), 1'b1);
      checkOutput("mid_sel0", 32'(sel), 32'd0);
      applyStimulus(4'b0001, 4'b0001, rndData(), 1'b1);

      // Granted requester goes silent.
      doReset("rst4");
      applyStimulus(4'b1000, 4'b0000, rndData(), 1'b1);
      checkOutput("wd_sel", 32'(sel), 32'd3);
      toCycle = 0;
      toCount = 0;
      for (int c = 1; c <= 20; c++) begin
         applyStimulus(4'b0000, 4'b0000, rndData(), 1'b1);
         if (obsTimeout === 1'b1) begin
            toCount++;
            if (toCycle == 0) toCycle = c;
         end
      end
`ifdef RR_ARB4_WDOG_EN
      checkOutput("wd_cycle", 32'(toCycle), 32'd16);
      checkOutput("wd_pulses", 32'(toCount), 32'd1);
      checkOutput("wd_idle", 32'(busy), 32'd0);
      applyStimulus(4'b1001, 4'b0000, rndData(), 1'b1);
      checkOutput("wd_ptr", 32'(sel), 32'd0);
`else
      checkOutput("wd_pulses", 32'(toCount), 32'd0);
      checkOutput("wd_held", 32'(busy), 32'd1);
      checkOutput("wd_sel_held", 32'(sel), 32'd3);
`endif

      // Reset during the second beat of a burst.
      doReset("rst5");
      startX = xfers;
      applyStimulus(4'b0010, 4'b0000, rndData(), 1'b1);
      applyStimulus(4'b0010, 4'b0000, rndData(), 1'b1);
      doReset("rstmid");
      checkOutput("rstmid_beats", 32'(xfers - startX), 32'd1);
      checkOutput("rstmid_sel", 32'(sel), 32'd0);
      applyStimulus(4'b1111, 4'b0000, rndData(), 1'b1);
      checkOutput("rstmid_ptr", 32'(sel), 32'd0);
      applyStimulus(4'b1111, 4'b1111, rndData(), 1'b1);

      // Random traffic.
      doReset("rst6");
      for (int c = 0; c < 1500; c++) begin
         logic [3:0] v;
         logic [3:0] l;
         v = 4'($urandom_range(0, 15));
         for (int b = 0; b < 4; b++) l[b] = ($urandom_range(0, 3) == 0);
         applyStimulus(v, l, rndData(), $urandom_range(0, 3) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rr_arb4.md
RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 Parameter DW SHALL default to 2 and set the payload width per requester.
REQ-002 Parameter WDOG_CYC SHALL default to 16 and set the watchdog idle-cycle limit.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 req_valid  in  4  SHALL carry per-requester valid; bit i belongs to requester i.
REQ-006 req_data  in  4*DW  SHALL carry the requester i payload in bits [i*DW +: DW].
REQ-007 req_last  in  4  SHALL mark the final beat of requester i's burst.
REQ-008 req_ready  out  4  SHALL be the per-requester ready, one-hot or zero.
REQ-009 out_valid  out  1  SHALL indicate a valid beat on the shared output.
REQ-010 out_ready  in  1  SHALL be the downstream ready.
REQ-011 out_data  out  DW  SHALL be the selected requester's payload.
REQ-012 out_last  out  1  SHALL be the selected requester's req_last.
REQ-013 sel  out  2  SHALL be the registered grant index, which drives the 4:1 mux select.
REQ-014 busy  out  1  SHALL be high while in GRANT.
REQ-015 timeout  out  1  SHALL be the one-cycle watchdog abort pulse.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-017 IDLE SHALL pick the first requester with req_valid set, searching from ptr+1 upward mod 4, register it into sel, and enter GRANT on the next edge. Arbitration latency is 1 cycle.
REQ-018 IDLE SHALL hold out_valid=0, req_ready=0 and busy=0.
REQ-019 IDLE with req_valid=0 SHALL stay in IDLE with sel unchanged.
REQ-020 GRANT SHALL drive the following signals combinationally, with no added latency:
- out_valid = req_valid[sel]
- out_data = req_data[sel]
- out_last = req_last[sel]
- req_ready[sel] = out_ready
- all other req_ready bits = 0
REQ-021 A transfer SHALL occur on a cycle with out_valid and out_ready both high.
REQ-022 A transfer with out_last=1 SHALL set ptr to sel and return the FSM to IDLE.
REQ-023 The grant SHALL NOT change mid-burst, whatever the other requesters do.
REQ-024 When several requesters request at once, the pick SHALL follow strict rotation, so each requester waits at most 3 bursts.
REQ-025 A requester dropping valid during GRANT SHALL hold the grant, subject to REQ-030.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously reset to the following values:
- state = IDLE
- ptr = 3, so requester 0 is first
- sel = 0
- all other outputs = 0
REQ-027 Reset asserted mid-burst SHALL abandon the burst immediately; no beat is completed.
REQ-028 rst_n release SHALL be synchronous to clk.

Configuration
REQ-029 Macro RR_ARB4_WDOG_EN SHALL compile the watchdog in when defined.
REQ-030 With RR_ARB4_WDOG_EN defined, the watchdog SHALL behave as follows:
- A 4-bit counter counts consecutive GRANT cycles with req_valid[sel]=0 and clears on any cycle that has it high.
- When the count reaches WDOG_CYC-1, the block SHALL pulse timeout for one cycle, set ptr to sel, and return to IDLE.
REQ-031 With RR_ARB4_WDOG_EN undefined, timeout SHALL be tied to 0, no counter SHALL exist, and the grant SHALL be held indefinitely.

Structure
REQ-032 Shared package arb_pkg SHALL hold the following definitions:
- NREQ = 4
- SELW = 2
- the state encoding (IDLE = 1'b0, GRANT = 1'b1)
- the WDOG_CYC default
REQ-033 The data and last path SHALL instantiate the existing mux41 sub-module (DW and 1 wide), driven by sel; the arbiter SHALL contain no separate data mux.

Verification
REQ-034 Single requester: reset, req_valid=4'b0100, 3-beat burst, out_ready=1 -> the following response:
- sel=2 one cycle after request
- 3 transfers
- IDLE after the last beat
- ptr=2
REQ-035 Full contention: req_valid=4'b1111 continuous, 1-beat bursts -> grant order 0,1,2,3,0 with 2 cycles per grant.
REQ-036 Backpressure: out_ready=0 for 5 cycles mid-burst -> req_ready[sel]=0, out_data stable, sel unchanged, no beat lost.
REQ-037 Mid-burst request: req 1 in burst, req 0 asserts -> req 0 is granted only after req 1's last beat.
REQ-038 Watchdog (RR_ARB4_WDOG_EN): granted requester drops valid for 16 cycles -> timeout pulses in the 16th cycle, then IDLE; without the macro, the grant is held and timeout=0.
REQ-039 Reset mid-burst: rst_n=0 during beat 2 -> all outputs 0 immediately, and sel=0 and ptr=3 after release.
